// File: rtl/spi_regbank_peripheral_pkg.sv
// Shared definitions for the SPI register-bank peripheral: R/W encoding, FSM
// state encoding and default field widths.
package spi_pkg;

   localparam logic RW_WRITE = 1'b1;
   localparam logic RW_READ  = 1'b0;

   localparam int unsigned SPI_DATA_W = 8;
   localparam int unsigned SPI_ADDR_W = 7;

   typedef logic [1:0] spi_state_t;

   localparam spi_state_t ST_IDLE = 2'd0;
   localparam spi_state_t ST_CMD  = 2'd1;
   localparam spi_state_t ST_DATA = 2'd2;

endpackage

// File: rtl/spi_regbank_peripheral_if.sv
// SPI pin bundle between an external controller (master) and the peripheral (slave).
interface spi_regbank_peripheral_if;

   logic nCS_in;
   logic SCLK_in;
   logic COPI_in;
   logic CIPO_out;
   logic CIPO_oe;

   modport master (
      output nCS_in,
      output SCLK_in,
      output COPI_in,
      input  CIPO_out,
      input  CIPO_oe
   );

   modport slave (
      input  nCS_in,
      input  SCLK_in,
      input  COPI_in,
      output CIPO_out,
      output CIPO_oe
   );

endinterface

// File: rtl/spi_regbank_peripheral_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, with rise/fall pulses
// derived from the last synchronizer stage.
module spi_sync_edge #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_async,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= {SYNC_STAGES{RST_VAL}};
         r_prev <= RST_VAL;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_level = r_sync[SYNC_STAGES-1];
   assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
   assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/spi_regbank_peripheral.sv
// SPI mode-0 register bank: burst write/read with address auto-increment,
// read-back on CIPO and a flat register vector for downstream logic.
module spi_regbank_peripheral
   import spi_pkg::*;
#(
   parameter int unsigned NUM_REGS    = 5,
   parameter int unsigned DATA_W      = SPI_DATA_W,
   parameter int unsigned ADDR_W      = SPI_ADDR_W,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   spi_regbank_peripheral_if.slave    spi,
   output logic [NUM_REGS*DATA_W-1:0] regs_out,
   output logic                       wr_pulse,
   output logic [ADDR_W-1:0]          wr_addr,
   output logic                       frame_err
);

   localparam int unsigned CMD_BITS = ADDR_W + 1;
   localparam int unsigned MAX_BITS = (CMD_BITS > DATA_W) ? CMD_BITS : DATA_W;
   localparam int unsigned CNT_W    = $clog2(MAX_BITS + 1);

   logic w_ncs_lvl, w_ncs_rise, w_ncs_fall;
   logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
   logic w_copi, w_copi_rise, w_copi_fall;
   logic w_unused;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_async (spi.nCS_in),
      .o_level (w_ncs_lvl),
      .o_rise  (w_ncs_rise),
      .o_fall  (w_ncs_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_async (spi.SCLK_in),
      .o_level (w_sclk_lvl),
      .o_rise  (w_sclk_rise),
      .o_fall  (w_sclk_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_async (spi.COPI_in),
      .o_level (w_copi),
      .o_rise  (w_copi_rise),
      .o_fall  (w_copi_fall)
   );

   assign w_unused = ^{w_sclk_lvl, w_copi_rise, w_copi_fall};

   spi_state_t           r_state;
   logic [CNT_W-1:0]     r_bit_cnt;
   logic [ADDR_W-1:0]    r_cmd_shift;
   logic [DATA_W-2:0]    r_rx_shift;
   logic [DATA_W-1:0]    r_tx_shift;
   logic                 r_tx_skip;
   logic [ADDR_W-1:0]    r_addr;
   logic                 r_rw;
   logic                 r_oe;
   logic                 r_wr_pulse;
   logic [ADDR_W-1:0]    r_wr_addr;
   logic                 r_frame_err;
   logic [DATA_W-1:0]    r_regs [NUM_REGS];

   logic [ADDR_W:0]      w_cmd_word;
   logic [DATA_W-1:0]    w_rx_word;
   logic [ADDR_W-1:0]    w_addr_next;
   logic [DATA_W-1:0]    w_rd_cmd;
   logic [DATA_W-1:0]    w_rd_next;
   logic [NUM_REGS-1:0]  w_wr_sel;
   logic                 w_cmd_last;
   logic                 w_word_last;

   assign w_cmd_word  = {r_cmd_shift, w_copi};
   assign w_rx_word   = {r_rx_shift, w_copi};
   assign w_addr_next = r_addr + ADDR_W'(1);
   assign w_cmd_last  = (r_bit_cnt == CNT_W'(CMD_BITS - 1));
   assign w_word_last = (r_bit_cnt == CNT_W'(DATA_W - 1));

   // Out-of-range addresses read as zero and select no register for writes.
   always_comb begin
      w_rd_cmd  = '0;
      w_rd_next = '0;
      w_wr_sel  = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (w_cmd_word[ADDR_W-1:0] == ADDR_W'(i)) w_rd_cmd = r_regs[i];
         if (w_addr_next == ADDR_W'(i))            w_rd_next = r_regs[i];
         if (r_addr == ADDR_W'(i))                 w_wr_sel[i] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_bit_cnt   <= '0;
         r_cmd_shift <= '0;
         r_rx_shift  <= '0;
         r_tx_shift  <= '0;
         r_tx_skip   <= 1'b0;
         r_addr      <= '0;
         r_rw        <= RW_READ;
         r_oe        <= 1'b0;
         r_wr_pulse  <= 1'b0;
         r_wr_addr   <= '0;
         r_frame_err <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      end else begin
         r_wr_pulse  <= 1'b0;
         r_frame_err <= 1'b0;
         // nCS rise takes priority over any SCLK edge seen in the same clk.
         if (w_ncs_rise) begin
            if (r_state != ST_IDLE && r_bit_cnt != '0) r_frame_err <= 1'b1;
            r_state <= ST_IDLE;
            r_oe    <= 1'b0;
         end else if (w_ncs_fall) begin
            r_state     <= ST_CMD;
            r_bit_cnt   <= '0;
            r_cmd_shift <= '0;
            r_rx_shift  <= '0;
            r_tx_shift  <= '0;
            r_tx_skip   <= 1'b0;
            r_oe        <= 1'b0;
         end else if (!w_ncs_lvl && r_state != ST_IDLE) begin
            if (w_sclk_rise) begin
               if (r_state == ST_CMD) begin
                  if (w_cmd_last) begin
                     r_rw      <= w_cmd_word[ADDR_W];
                     r_addr    <= w_cmd_word[ADDR_W-1:0];
                     r_bit_cnt <= '0;
                     r_state   <= ST_DATA;
                     if (w_cmd_word[ADDR_W] == RW_READ) begin
                        r_oe       <= 1'b1;
                        r_tx_shift <= w_rd_cmd;
                        r_tx_skip  <= 1'b1;
                     end
                  end else begin
                     r_cmd_shift <= w_cmd_word[ADDR_W-1:0];
                     r_bit_cnt   <= r_bit_cnt + CNT_W'(1);
                  end
               end else if (w_word_last) begin
                  r_bit_cnt <= '0;
                  r_addr    <= w_addr_next;
                  if (r_rw == RW_WRITE) begin
                     if (|w_wr_sel) begin
                        r_wr_pulse <= 1'b1;
                        r_wr_addr  <= r_addr;
                     end
                     for (int i = 0; i < NUM_REGS; i++) begin
                        if (w_wr_sel[i]) r_regs[i] <= w_rx_word;
                     end
                  end else begin
                     r_tx_shift <= w_rd_next;
                     r_tx_skip  <= 1'b1;
                  end
               end else begin
                  r_rx_shift <= w_rx_word[DATA_W-2:0];
                  r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
               end
            end else if (w_sclk_fall && r_state == ST_DATA && r_rw == RW_READ) begin
               // The falling edge right after a load keeps the freshly loaded MSB.
               if (r_tx_skip) r_tx_skip <= 1'b0;
               else           r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
      assign regs_out[g*DATA_W +: DATA_W] = r_regs[g];
   end

   assign spi.CIPO_out = r_tx_shift[DATA_W-1];
   assign spi.CIPO_oe  = r_oe;
   assign wr_pulse     = r_wr_pulse;
   assign wr_addr      = r_wr_addr;
   assign frame_err    = r_frame_err;

endmodule

// File: tb/tb_spi_regbank_peripheral.sv
// Directed bench for spi_regbank_peripheral: an SPI controller task drives frames while a
// register-level model predicts commits, CIPO bits and frame errors.
module tb_spi_regbank_peripheral;

   localparam int NR = 5;
   localparam int DW = 8;
   localparam int AW = 7;
   localparam int HALF = 50;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   logic clk = 1'b0;
   logic rst_n;
   logic [NR*DW-1:0] regs_out;
   logic wr_pulse;
   logic [AW-1:0] wr_addr;
   logic frame_err;

   always #5 clk = ~clk;

   spi_regbank_peripheral_if spi_if ();

   spi_regbank_peripheral #(
      .NUM_REGS    (NR),
      .DATA_W      (DW),
      .ADDR_W      (AW),
      .SYNC_STAGES (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .spi       (spi_if),
      .regs_out  (regs_out),
      .wr_pulse  (wr_pulse),
      .wr_addr   (wr_addr),
      .frame_err (frame_err)
   );

   int total = 0;
   int bad = 0;
   logic [DW-1:0] m_regs [NR];
   logic [DW-1:0] shadow [NR];
   wr_t exp_q [$];
   int pulses_seen = 0;
   int err_seen = 0;
   int err_exp = 0;
   logic [DW-1:0] rd_cap [8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [NR*DW-1:0] flat_shadow();
      logic [NR*DW-1:0] v;
      for (int i = 0; i < NR; i++) v[i*DW +: DW] = shadow[i];
      return v;
   endfunction

   // Per-cycle compare: commits must arrive in model order and the register
   // vector must always equal the model after the commits seen so far.
   always @(negedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NR; i++) shadow[i] = '0;
         exp_q.delete();
         check("rst_regs_out", 64'(regs_out), 64'd0);
      end else begin
         if (wr_pulse) begin
            pulses_seen++;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_wr: got wr_addr %0h expected no write", wr_addr);
            end else begin
               wr_t w;
               w = exp_q.pop_front();
               check("wr_addr", 64'(wr_addr), 64'(w.a));
               shadow[w.a] = w.d;
            end
         end
         if (frame_err) err_seen++;
         check("regs_out", 64'(regs_out), 64'(flat_shadow()));
      end
   end

   // Drives one frame of nbits SCLK cycles; wd holds data words, word 0 in the low byte.
   task automatic frame(input logic rw, input int addr, input logic [63:0] wd, input int nbits,
                        input bit reset_at_end);
      logic [7:0] cmd;
      cmd = {rw, 7'(addr)};
      for (int i = 0; i < 8; i++) rd_cap[i] = '0;
      spi_if.nCS_in = 1'b0;
      #HALF;
      for (int b = 0; b < nbits; b++) begin
         int k;
         int w;
         int a;
         logic v;
         logic [DW-1:0] eb;
         logic [DW-1:0] word;
         k = b - 8;
         w = (k >= 0) ? k / 8 : 0;
         a = (addr + w) % 128;
         word = wd[8*w +: 8];
         v = (b < 8) ? cmd[7-b] : word[7 - (k % 8)];
         spi_if.COPI_in = v;
         #HALF;
         if (b >= 8 && rw == 1'b0) begin
            eb = (a < NR) ? m_regs[a] : 8'h00;
            check("cipo_bit", 64'(spi_if.CIPO_out), 64'(eb[7 - (k % 8)]));
            check("cipo_oe_read", 64'(spi_if.CIPO_oe), 64'd1);
            rd_cap[w][7 - (k % 8)] = spi_if.CIPO_out;
         end else begin
            check("cipo_oe_low", 64'(spi_if.CIPO_oe), 64'd0);
         end
         spi_if.SCLK_in = 1'b1;
         if (b >= 8 && rw == 1'b1 && (k % 8) == 7 && a < NR) begin
            exp_q.push_back('{a: 7'(a), d: word});
            m_regs[a] = word;
         end
         #HALF;
         spi_if.SCLK_in = 1'b0;
      end
      if (reset_at_end) begin
         rst_n = 1'b0;
         #1;
         check("rst_now_regs", 64'(regs_out), 64'd0);
         check("rst_now_oe", 64'(spi_if.CIPO_oe), 64'd0);
         #9;
         spi_if.nCS_in = 1'b1;
         spi_if.COPI_in = 1'b0;
         for (int i = 0; i < NR; i++) m_regs[i] = '0;
         #20;
         rst_n = 1'b1;
         #HALF;
      end else begin
         #HALF;
         spi_if.nCS_in = 1'b1;
         if ((nbits > 0 && nbits < 8) || (nbits > 8 && ((nbits - 8) % 8) != 0)) err_exp++;
         #200;
         check("cipo_oe_end", 64'(spi_if.CIPO_oe), 64'd0);
         check("frame_err_count", 64'(err_seen), 64'(err_exp));
      end
   endtask

   initial begin
      rst_n = 1'b0;
      spi_if.nCS_in = 1'b1;
      spi_if.SCLK_in = 1'b0;
      spi_if.COPI_in = 1'b0;
      for (int i = 0; i < NR; i++) m_regs[i] = '0;
      #32;
      rst_n = 1'b1;
      #100;
      check("reset_regs", 64'(regs_out), 64'd0);
      check("reset_wr_pulse", 64'(wr_pulse), 64'd0);
      check("reset_wr_addr", 64'(wr_addr), 64'd0);
      check("reset_frame_err", 64'(frame_err), 64'd0);
      check("reset_cipo", 64'(spi_if.CIPO_out), 64'd0);
      check("reset_oe", 64'(spi_if.CIPO_oe), 64'd0);

      frame(1'b1, 3, 64'hA5, 16, 1'b0);
      check("t1_regs", 64'(regs_out), 64'h00_A5_00_00_00);
      check("t1_pulses", 64'(pulses_seen), 64'd1);

      frame(1'b1, 0, 64'h55_44_33_22_11, 48, 1'b0);
      check("t2_regs", 64'(regs_out), 64'h55_44_33_22_11);
      check("t2_pulses", 64'(pulses_seen), 64'd6);

      frame(1'b0, 1, 64'h0, 24, 1'b0);
      check("t3_rd0", 64'(rd_cap[0]), 64'h22);
      check("t3_rd1", 64'(rd_cap[1]), 64'h33);
      check("t3_regs", 64'(regs_out), 64'h55_44_33_22_11);

      frame(1'b1, 7, 64'hFF, 16, 1'b0);
      check("t4_pulses", 64'(pulses_seen), 64'd6);
      check("t4_regs", 64'(regs_out), 64'h55_44_33_22_11);
      frame(1'b0, 7, 64'h0, 16, 1'b0);
      check("t4_rd7", 64'(rd_cap[0]), 64'h00);

      frame(1'b1, 2, 64'h99, 12, 1'b0);
      check("t5_err", 64'(err_seen), 64'd1);
      check("t5_regs", 64'(regs_out), 64'h55_44_33_22_11);
      frame(1'b1, 0, 64'h77_66, 20, 1'b0);
      check("t5b_err", 64'(err_seen), 64'd2);
      check("t5b_regs", 64'(regs_out), 64'h55_44_33_22_66);
      check("t5b_pulses", 64'(pulses_seen), 64'd7);

      frame(1'b1, 0, 64'h88_12, 19, 1'b1);
      check("t6_pulses", 64'(pulses_seen), 64'd8);
      check("t6_regs_reset", 64'(regs_out), 64'd0);
      frame(1'b1, 0, 64'h3C, 16, 1'b0);
      check("t6_regs", 64'(regs_out), 64'h3C);
      check("t6_pulses_after", 64'(pulses_seen), 64'd9);
      check("t6_err", 64'(err_seen), 64'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
